// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the program-counter fetch unit: FSM encoding,
// PC arithmetic constants and the NOP instruction encoding.
package pc_fetch_unit_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_ERR   = 2'd3
    } fetch_state_e;

    // Sequential PC step and the architectural r15 read-ahead offset
    localparam logic [31:0] PC_INC     = 32'd4;
    localparam logic [31:0] R15_OFFSET = 32'd8;

    // MOV r0,r0 -- shown to decode whenever no real instruction is held
    localparam logic [31:0] NOP_ENC    = 32'hE1A0_0000;

    // Force an address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_watchdog.sv
// Fetch watchdog: counts cycles spent waiting for an instruction-memory
// acknowledge and flags expiry on the cycle the count reaches WAIT_MAX.
module fetch_watchdog #(
    parameter int WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    // Expiry fires during the WAIT_MAX-th enabled cycle, i.e. when the
    // count of previously elapsed cycles equals WAIT_MAX-1.
    localparam logic [7:0] LIMIT = 8'(WAIT_MAX - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clear dominates, otherwise step while enabled
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (enable_i) begin
            count_d = count_q + 8'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // A cycle that clears the counter (e.g. an acknowledge) never expires
    assign expired_o = enable_i && !clear_i && (count_q == LIMIT);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch front end. Issues one request per
// instruction over a req/ack handshake, holds the fetched word for decode
// (absorbing stalls), handles branch redirects that arrive mid-fetch, and
// parks in a sticky error state if memory stops answering.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          WAIT_MAX   = 16,
    parameter logic [31:0] NOP_WORD   = NOP_ENC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic [31:0] pc_out_o,
    output logic [31:0] r15_o,
    output logic        fetch_err_o
);

    localparam logic [31:0] RESET_PC = word_align(RESET_ADDR);

    fetch_state_e state_q, state_d;

    logic [31:0] pc_q,        pc_d;
    logic [31:0] pend_pc_q,   pend_pc_d;
    logic        redirect_q,  redirect_d;
    logic [31:0] instr_q,     instr_d;
    logic        instr_vld_q, instr_vld_d;
    logic        fetch_err_q, fetch_err_d;

    logic        in_fetch;
    logic        wd_clear;
    logic        wd_expired;
    logic [31:0] target_aligned;
    logic        unused_target_bits;

    assign in_fetch       = (state_q == ST_FETCH);
    assign target_aligned = word_align(branch_target_i);

    // Low target bits are architecturally don't-care
    assign unused_target_bits = ^branch_target_i[1:0];

    // Restart the wait count whenever memory answers or we are not fetching,
    // so every new request gets the full WAIT_MAX budget.
    assign wd_clear = imem_ack_i || !in_fetch;

    fetch_watchdog #(
        .WAIT_MAX (WAIT_MAX)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (wd_clear),
        .enable_i  (in_fetch),
        .expired_o (wd_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (wd_expired) begin
                    state_d = ST_ERR;
                end else if (imem_ack_i && !branch_taken_i && !redirect_q) begin
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (branch_taken_i || !stall_i) begin
                    state_d = ST_FETCH;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: the request is simply "we are in FETCH", so an async
    // reset (which forces IDLE) drops it immediately.
    always_comb begin
        imem_req_o = 1'b0;
        if (state_q == ST_FETCH) begin
            imem_req_o = 1'b1;
        end
    end

    // Datapath next values: PC, pending redirect, held instruction, error
    always_comb begin
        pc_d        = pc_q;
        pend_pc_d   = pend_pc_q;
        redirect_d  = redirect_q;
        instr_d     = instr_q;
        instr_vld_d = instr_vld_q;
        fetch_err_d = fetch_err_q;
        unique case (state_q)
            ST_IDLE: begin
                instr_vld_d = 1'b0;
            end
            ST_FETCH: begin
                if (wd_expired) begin
                    fetch_err_d = 1'b1;
                    instr_vld_d = 1'b0;
                end else if (branch_taken_i) begin
                    if (imem_ack_i) begin
                        // Word in flight belongs to the old path: drop it
                        pc_d       = target_aligned;
                        redirect_d = 1'b0;
                    end else begin
                        // Keep the outstanding request stable; redirect on ack
                        pend_pc_d  = target_aligned;
                        redirect_d = 1'b1;
                    end
                end else if (imem_ack_i) begin
                    if (redirect_q) begin
                        pc_d       = pend_pc_q;
                        redirect_d = 1'b0;
                    end else begin
                        instr_d     = imem_rdata_i;
                        instr_vld_d = 1'b1;
                    end
                end
            end
            ST_VALID: begin
                if (branch_taken_i) begin
                    pc_d        = target_aligned;
                    instr_d     = NOP_WORD;
                    instr_vld_d = 1'b0;
                end else if (!stall_i) begin
                    pc_d        = pc_q + PC_INC;
                    instr_d     = NOP_WORD;
                    instr_vld_d = 1'b0;
                end
            end
            ST_ERR: begin
                instr_vld_d = 1'b0;
                fetch_err_d = 1'b1;
            end
            default: begin
                instr_vld_d = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            pend_pc_q   <= RESET_PC;
            redirect_q  <= 1'b0;
            instr_q     <= NOP_WORD;
            instr_vld_q <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pend_pc_q   <= pend_pc_d;
            redirect_q  <= redirect_d;
            instr_q     <= instr_d;
            instr_vld_q <= instr_vld_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // The PC only advances when the held word is released, so it doubles
    // as the address of the instruction presented to decode.
    assign imem_addr_o   = pc_q;
    assign pc_out_o      = pc_q;
    assign r15_o         = pc_q + R15_OFFSET;
    assign instr_o       = instr_q;
    assign instr_valid_o = instr_vld_q;
    assign fetch_err_o   = fetch_err_q;

endmodule
